key_debounce: RTL

- Upstream conditioning stage for a raw, asynchronous, bouncing input such as a push-button or mechanical switch.
- Synchronises the input into the CLK domain, then qualifies each level change with a stability counter.
- Presents a clean, glitch-free level on OUT. OUT feeds directly into the rising-edge pulse detector downstream.

---
 rtl/key_debounce.sv | 122 ++++++++++++
 1 files changed

// File: rtl/key_debounce.sv
// key_debounce: two-flop synchroniser plus stability-qualified level FSM.
// Produces a clean registered level and a busy flag for bouncing inputs.
module key_debounce #(
  parameter int unsigned STABLE_CYCLES = 1000000,
  parameter int unsigned CNT_W         = 20
) (
  input  logic CLK,
  input  logic RST,
  input  logic IN,
  output logic OUT,
  output logic BUSY
);

  typedef enum logic [1:0] {
    S_LOW  = 2'b00,
    WAIT_H = 2'b01,
    S_HIGH = 2'b10,
    WAIT_L = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  logic             s1;
  logic             s2;
  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             out_nx;
  logic             busy_nx;

  // bring the raw input into the CLK domain
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= IN;
      s2 <= s1;
    end
  end

  // state, counter and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_LOW;
      cnt   <= CNT_ZERO;
      OUT   <= 1'b0;
      BUSY  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      OUT   <= out_nx;
      BUSY  <= busy_nx;
    end
  end

  // next state: a candidate level must be seen STABLE_CYCLES
  // times in a row; any opposite sample drops back to the
  // settled state with the counter cleared
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      S_LOW: begin
        if (s2) begin
          state_nx = WAIT_H;
          cnt_nx   = CNT_ONE;
        end
      end
      WAIT_H: begin
        if (!s2) begin
          state_nx = S_LOW;
          cnt_nx   = CNT_ZERO;
        end else if (cnt == CNT_LAST) begin
          state_nx = S_HIGH;
          cnt_nx   = CNT_ZERO;
        end else begin
          cnt_nx   = cnt + CNT_ONE;
        end
      end
      S_HIGH: begin
        if (!s2) begin
          state_nx = WAIT_L;
          cnt_nx   = CNT_ONE;
        end
      end
      WAIT_L: begin
        if (s2) begin
          state_nx = S_HIGH;
          cnt_nx   = CNT_ZERO;
        end else if (cnt == CNT_LAST) begin
          state_nx = S_LOW;
          cnt_nx   = CNT_ZERO;
        end else begin
          cnt_nx   = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nx = S_LOW;
        cnt_nx   = CNT_ZERO;
      end
    endcase
  end

  // outputs follow the next state so they share its edge
  always_comb begin
    out_nx  = 1'b0;
    busy_nx = 1'b0;
    case (state_nx)
      S_LOW:   begin out_nx = 1'b0; busy_nx = 1'b0; end
      WAIT_H:  begin out_nx = 1'b0; busy_nx = 1'b1; end
      S_HIGH:  begin out_nx = 1'b1; busy_nx = 1'b0; end
      WAIT_L:  begin out_nx = 1'b1; busy_nx = 1'b1; end
      default: begin out_nx = 1'b0; busy_nx = 1'b0; end
    endcase
  end

endmodule
